// File: rtl/amigaclks_pkg.sv
// Shared definitions for the Amiga clock block: sequencer state encoding,
// default timing constants and the vidmode pin encodings.
package amigaclks_pkg;

    // States of the TMDS PLL mode sequencer
    typedef enum logic [2:0] {
        WAIT_SYS,
        WAIT_VID,
        RUN,
        QUIESCE,
        DROP,
        RELOCK
    } vseq_state_t;

    // Default timing in clk_28m cycles
    localparam int DEF_SETTLE_CYCLES  = 1024;
    localparam int DEF_QUIESCE_CYCLES = 64;
    localparam int DEF_DROP_CYCLES    = 256;
    localparam int DEF_RELOCK_TIMEOUT = 65536;

    // vidmode pin encoding seen by the clock block
    localparam logic VIDMODE_28M = 1'b1;
    localparam logic VIDMODE_56M = 1'b0;

    // Largest of four timing values, used to size the shared counter
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/vidmode_sequencer_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level, clearing to 0.
module sync_bit (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the asynchronous level and let it settle for one more cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vidmode_sequencer.sv
// Owns the vidmode input of the reconfigurable TMDS PLL: switches between
// 28 MHz native and 56 MHz RTG pixel clocks, holds the video pipeline in
// reset while the clocks are unsettled and reverts on a failed relock.
module vidmode_sequencer
    import amigaclks_pkg::*;
#(
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int QUIESCE_CYCLES = DEF_QUIESCE_CYCLES,
    parameter int DROP_CYCLES    = DEF_DROP_CYCLES,
    parameter int RELOCK_TIMEOUT = DEF_RELOCK_TIMEOUT
) (
    input  logic clk_28m,
    input  logic reset,
    input  logic locked,
    input  logic video_locked,
    input  logic rtg_req,
    output logic vidmode,
    output logic video_reset,
    output logic busy,
    output logic mode_err,
    output logic rtg_active
);

    localparam int CNT_MAX = max4(SETTLE_CYCLES, QUIESCE_CYCLES, DROP_CYCLES, RELOCK_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] QUIESCE_LOAD = CNT_W'(QUIESCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DROP_LOAD    = CNT_W'(DROP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(RELOCK_TIMEOUT - 1);

    logic             locked_s;
    logic             video_locked_s;
    vseq_state_t      state;
    vseq_state_t      state_nxt;
    // cnt times settle/quiesce/drop windows; tmo bounds the whole RELOCK stay
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] tmo;
    logic [CNT_W-1:0] tmo_nxt;
    logic             err_req;
    logic             err_req_nxt;
    // set while the relock attempt follows a revert, so a second failure stops flipping
    logic             reverted;
    logic             reverted_nxt;
    logic             vidmode_nxt;
    logic             video_reset_nxt;
    logic             busy_nxt;
    logic             mode_err_nxt;
    logic             rtg_active_nxt;

    sync_bit u_sync_locked (
        .clk   (clk_28m),
        .reset (reset),
        .d     (locked),
        .q     (locked_s)
    );

    sync_bit u_sync_video_locked (
        .clk   (clk_28m),
        .reset (reset),
        .d     (video_locked),
        .q     (video_locked_s)
    );

    // State register
    always_ff @(posedge clk_28m) begin
        if (reset) state <= WAIT_SYS;
        else       state <= state_nxt;
    end

    // Next-state decision; system lock loss overrides every other transition
    always_comb begin
        state_nxt = state;
        if (state != WAIT_SYS && !locked_s) begin
            state_nxt = WAIT_SYS;
        end else begin
            case (state)
                WAIT_SYS: if (locked_s && cnt == '0) state_nxt = WAIT_VID;
                WAIT_VID: if (video_locked_s && cnt == '0) state_nxt = RUN;
                RUN: begin
                    if (rtg_req != rtg_active && !(mode_err && rtg_req == err_req))
                        state_nxt = QUIESCE;
                end
                QUIESCE:  if (cnt == '0) state_nxt = DROP;
                DROP:     if (!video_locked_s || cnt == '0) state_nxt = RELOCK;
                RELOCK: begin
                    if (video_locked_s && cnt == '0) state_nxt = RUN;
                    else if (tmo == '0)              state_nxt = reverted ? WAIT_VID : DROP;
                end
                default:  state_nxt = WAIT_SYS;
            endcase
        end
    end

    // Counter loads/decrements and next values of the registered outputs
    always_comb begin
        cnt_nxt      = cnt;
        tmo_nxt      = tmo;
        vidmode_nxt  = vidmode;
        mode_err_nxt = mode_err;
        err_req_nxt  = err_req;
        reverted_nxt = reverted;

        if (state_nxt != state) begin
            case (state_nxt)
                WAIT_SYS, WAIT_VID: cnt_nxt = SETTLE_LOAD;
                RELOCK: begin
                    cnt_nxt = SETTLE_LOAD;
                    tmo_nxt = TIMEOUT_LOAD;
                end
                QUIESCE:  cnt_nxt = QUIESCE_LOAD;
                DROP:     cnt_nxt = DROP_LOAD;
                default:  cnt_nxt = '0;
            endcase
        end else begin
            case (state)
                WAIT_SYS: cnt_nxt = locked_s ? cnt - 1'b1 : SETTLE_LOAD;
                WAIT_VID: cnt_nxt = video_locked_s ? cnt - 1'b1 : SETTLE_LOAD;
                RELOCK: begin
                    cnt_nxt = video_locked_s ? cnt - 1'b1 : SETTLE_LOAD;
                    tmo_nxt = tmo - 1'b1;
                end
                QUIESCE, DROP: cnt_nxt = cnt - 1'b1;
                default: cnt_nxt = cnt;
            endcase
        end

        if (state == QUIESCE && state_nxt == DROP) begin
            vidmode_nxt  = ~vidmode;
            err_req_nxt  = rtg_req;
            reverted_nxt = 1'b0;
        end
        if (state == RELOCK && state_nxt == DROP) begin
            vidmode_nxt  = ~vidmode;
            mode_err_nxt = 1'b1;
            reverted_nxt = 1'b1;
        end
        if (state == RELOCK && state_nxt == WAIT_VID)
            mode_err_nxt = 1'b1;
        // a withdrawn request acknowledges the error, but only while staying in RUN
        if (state == RUN && state_nxt == RUN && rtg_req == rtg_active)
            mode_err_nxt = 1'b0;

        video_reset_nxt = (state_nxt != RUN);
        busy_nxt        = (state_nxt != RUN);
        rtg_active_nxt  = ~vidmode_nxt;
    end

    // Counters, request latch and registered outputs
    always_ff @(posedge clk_28m) begin
        if (reset) begin
            cnt         <= SETTLE_LOAD;
            tmo         <= '0;
            err_req     <= 1'b0;
            reverted    <= 1'b0;
            vidmode     <= VIDMODE_28M;
            video_reset <= 1'b1;
            busy        <= 1'b1;
            mode_err    <= 1'b0;
            rtg_active  <= ~VIDMODE_28M;
        end else begin
            cnt         <= cnt_nxt;
            tmo         <= tmo_nxt;
            err_req     <= err_req_nxt;
            reverted    <= reverted_nxt;
            vidmode     <= vidmode_nxt;
            video_reset <= video_reset_nxt;
            busy        <= busy_nxt;
            mode_err    <= mode_err_nxt;
            rtg_active  <= rtg_active_nxt;
        end
    end

endmodule

// File: tb/tb_vidmode_sequencer.sv
// Bench for vidmode_sequencer: a phase/elapsed-time model checked every
// cycle, plus hand-computed latencies for each directed scenario.
module tb_vidmode_sequencer;

    localparam int S = 8;
    localparam int Q = 4;
    localparam int D = 6;
    localparam int T = 40;

    localparam int P_SYS  = 0;
    localparam int P_VID  = 1;
    localparam int P_RUN  = 2;
    localparam int P_QUI  = 3;
    localparam int P_DROP = 4;
    localparam int P_REL  = 5;

    logic clk_28m = 1'b0;
    logic reset = 1'b1;
    logic locked = 1'b0;
    logic video_locked = 1'b0;
    logic rtg_req = 1'b0;
    logic vidmode, video_reset, busy, mode_err, rtg_active;

    int n_checks = 0;
    int n_fail = 0;

    int m_phase = P_SYS;
    int m_age = 0;
    int m_good = 0;
    bit m_vm = 1'b1, m_err = 1'b0, m_err_req = 1'b0, m_rev = 1'b0;
    bit m_ls1 = 1'b0, m_ls2 = 1'b0, m_vs1 = 1'b0, m_vs2 = 1'b0;
    bit chk_en = 1'b0;

    always #5 clk_28m = ~clk_28m;

    vidmode_sequencer #(
        .SETTLE_CYCLES  (S),
        .QUIESCE_CYCLES (Q),
        .DROP_CYCLES    (D),
        .RELOCK_TIMEOUT (T)
    ) dut (
        .clk_28m      (clk_28m),
        .reset        (reset),
        .locked       (locked),
        .video_locked (video_locked),
        .rtg_req      (rtg_req),
        .vidmode      (vidmode),
        .video_reset  (video_reset),
        .busy         (busy),
        .mode_err     (mode_err),
        .rtg_active   (rtg_active)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d cycles, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Count rising edges until the selected output reaches val (bounded)
    task automatic edges_until(input int sel, input logic val, input int limit, output int k);
        logic s;
        k = 0;
        do begin
            @(posedge clk_28m);
            #1;
            k++;
            case (sel)
                0:       s = video_reset;
                1:       s = vidmode;
                default: s = busy;
            endcase
        end while (s !== val && k < limit);
    endtask

    // Reference behaviour: phases with elapsed and consecutive-good counts
    always @(posedge clk_28m) begin : model
        bit ls, vs;
        int nxt;
        ls = m_ls2;
        vs = m_vs2;
        if (reset) begin
            m_phase = P_SYS; m_age = 0; m_good = 0;
            m_vm = 1'b1; m_err = 1'b0; m_err_req = 1'b0; m_rev = 1'b0;
            m_ls1 = 1'b0; m_ls2 = 1'b0; m_vs1 = 1'b0; m_vs2 = 1'b0;
            chk_en = 1'b1;
        end else begin
            nxt = m_phase;
            if (m_phase != P_SYS && !ls) begin
                nxt = P_SYS;
            end else begin
                case (m_phase)
                    P_SYS: begin
                        m_good = ls ? m_good + 1 : 0;
                        if (m_good == S) nxt = P_VID;
                    end
                    P_VID: begin
                        m_good = vs ? m_good + 1 : 0;
                        if (m_good == S) nxt = P_RUN;
                    end
                    P_RUN: begin
                        if (rtg_req == !m_vm) m_err = 1'b0;
                        else if (!(m_err && rtg_req == m_err_req)) nxt = P_QUI;
                    end
                    P_QUI: begin
                        m_age++;
                        if (m_age == Q) begin
                            m_vm = !m_vm; m_err_req = rtg_req; m_rev = 1'b0; nxt = P_DROP;
                        end
                    end
                    P_DROP: begin
                        m_age++;
                        if (!vs || m_age == D) nxt = P_REL;
                    end
                    default: begin
                        m_age++;
                        m_good = vs ? m_good + 1 : 0;
                        if (m_good == S) nxt = P_RUN;
                        else if (m_age == T) begin
                            m_err = 1'b1;
                            if (!m_rev) begin
                                m_vm = !m_vm; m_rev = 1'b1; nxt = P_DROP;
                            end else begin
                                nxt = P_VID;
                            end
                        end
                    end
                endcase
            end
            if (nxt != m_phase) begin
                m_phase = nxt; m_age = 0; m_good = 0;
            end
            m_ls2 = m_ls1; m_ls1 = locked;
            m_vs2 = m_vs1; m_vs1 = video_locked;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk_28m) begin
        if (chk_en) begin
            check("vidmode", vidmode, m_vm);
            check("video_reset", video_reset, m_phase != P_RUN);
            check("busy", busy, m_phase != P_RUN);
            check("mode_err", mode_err, m_err);
            check("rtg_active", rtg_active, !m_vm);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        locked = 1'b1;
        video_locked = 1'b1;
        repeat (3) @(negedge clk_28m);
        check("rst_vidmode", vidmode, 1'b1);
        check("rst_video_reset", video_reset, 1'b1);
        check("rst_busy", busy, 1'b1);
        check("rst_mode_err", mode_err, 1'b0);
        check("rst_rtg_active", rtg_active, 1'b0);

        // Power-up: 2 sync + 8 system settle + 8 video settle
        reset = 1'b0;
        edges_until(0, 1'b0, 100, k);
        lit("powerup_latency", k, 18);
        check("powerup_vidmode", vidmode, 1'b1);
        check("powerup_busy", busy, 1'b0);

        // Switch to RTG with a visible 10-cycle PLL drop
        @(negedge clk_28m);
        rtg_req = 1'b1;
        @(posedge clk_28m); #1;
        check("req_to_video_reset", video_reset, 1'b1);
        edges_until(1, 1'b0, 50, k);
        lit("quiesce_len", k, 4);
        @(negedge clk_28m);
        video_locked = 1'b0;
        repeat (10) @(negedge clk_28m);
        video_locked = 1'b1;
        edges_until(2, 1'b0, 100, k);
        lit("relock_after_drop", k, 10);
        check("switch_rtg_active", rtg_active, 1'b1);

        // Back to native with no visible drop: 1 + 4 quiesce + 6 drop + 8 settle
        @(negedge clk_28m);
        rtg_req = 1'b0;
        edges_until(2, 1'b0, 100, k);
        lit("no_drop_switch", k, 19);
        check("no_drop_vidmode", vidmode, 1'b1);

        // Relock failure: revert 3 + 40 cycles after the flip
        @(negedge clk_28m);
        rtg_req = 1'b1;
        edges_until(1, 1'b0, 50, k);
        lit("flip_latency", k, 5);
        @(negedge clk_28m);
        video_locked = 1'b0;
        edges_until(1, 1'b1, 100, k);
        lit("revert_time", k, 43);
        check("revert_mode_err", mode_err, 1'b1);
        @(negedge clk_28m);
        video_locked = 1'b1;
        repeat (30) @(negedge clk_28m);
        check("blocked_busy", busy, 1'b0);
        check("blocked_vidmode", vidmode, 1'b1);
        check("blocked_mode_err", mode_err, 1'b1);
        rtg_req = 1'b0;
        @(posedge clk_28m); #1;
        check("withdraw_clears_err", mode_err, 1'b0);

        // Glitch during relock settling restarts the settle count
        @(negedge clk_28m);
        rtg_req = 1'b1;
        edges_until(1, 1'b0, 50, k);
        repeat (9) @(negedge clk_28m);
        video_locked = 1'b0;
        @(negedge clk_28m);
        video_locked = 1'b1;
        edges_until(2, 1'b0, 100, k);
        lit("glitch_restart", k, 10);
        check("glitch_rtg_active", rtg_active, 1'b1);

        // System lock loss mid-quiesce: no flip, pipeline stays in reset
        @(negedge clk_28m);
        rtg_req = 1'b0;
        @(posedge clk_28m); #1;
        check("quiesce_entry", video_reset, 1'b1);
        @(negedge clk_28m);
        locked = 1'b0;
        repeat (5) @(posedge clk_28m);
        #1;
        check("lockloss_vidmode", vidmode, 1'b0);
        check("lockloss_video_reset", video_reset, 1'b1);
        @(negedge clk_28m);
        locked = 1'b1;
        edges_until(2, 1'b0, 100, k);
        lit("lockloss_recovery", k, 18);
        edges_until(1, 1'b1, 50, k);
        edges_until(2, 1'b0, 100, k);

        // Two relock failures: revert, then give up into WAIT_VID
        @(negedge clk_28m);
        rtg_req = 1'b1;
        edges_until(1, 1'b0, 50, k);
        @(negedge clk_28m);
        video_locked = 1'b0;
        repeat (100) @(negedge clk_28m);
        check("double_fail_vidmode", vidmode, 1'b1);
        check("double_fail_mode_err", mode_err, 1'b1);
        check("double_fail_busy", busy, 1'b1);
        video_locked = 1'b1;
        edges_until(2, 1'b0, 100, k);
        lit("wait_vid_settle", k, 10);
        check("double_fail_blocked", mode_err, 1'b1);

        // Reset mid-switch restores native mode on the next edge
        @(negedge clk_28m);
        rtg_req = 1'b0;
        @(negedge clk_28m);
        rtg_req = 1'b1;
        edges_until(1, 1'b0, 50, k);
        @(negedge clk_28m);
        reset = 1'b1;
        @(posedge clk_28m); #1;
        check("midreset_vidmode", vidmode, 1'b1);
        check("midreset_video_reset", video_reset, 1'b1);
        check("midreset_rtg_active", rtg_active, 1'b0);
        @(negedge clk_28m);
        reset = 1'b0;
        repeat (5) @(negedge clk_28m);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
